// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Takes an instruction stream (5-bit opcode + 22-bit operand) over a
//   valid/ready handshake. It checks each opcode, builds the 27-bit
//   instruction word and writes the words in order into instruction memory,
//   starting at address 0. The processor core stays in reset until a HALT
//   word has been written.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          1-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_valid/ready handshake for one instruction field
//   in_opcode      opcode, placed in word bits [26:22]
//   in_operand     operand, placed in word bits [21:0]
//   imem_we/addr/wdata  registered imem write port (one pulse per word)
//   core_rst       1 = core held in reset
//   busy/done/err  state flags for LOAD / DONE / ERR
//   err_code       00 none, 01 illegal opcode, 10 overflow
//   word_count     words written in the current or last load
module imem_program_loader #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_opcode,
   input  logic [21:0]       in_operand,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [26:0]       imem_wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [4:0] OP_HALT = 5'b10000;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_DONE = 2'b10,
      S_ERR  = 2'b11
   } state_t;

   // Opcodes the decode stage does not implement.
   function automatic logic is_illegal(input logic [4:0] op);
      case (op)
         5'b11001, 5'b11100, 5'b11101, 5'b11110, 5'b01111: is_illegal = 1'b1;
         default:                                          is_illegal = 1'b0;
      endcase
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [ADDR_W-1:0]   wr_ptr_r;
   logic [ADDR_W:0]     word_count_r;
   logic [1:0]          err_code_r;
   logic                imem_we_r;
   logic [ADDR_W-1:0]   imem_addr_r;
   logic [26:0]         imem_wdata_r;

   logic                xfer_s;
   logic                illegal_s;
   logic                halt_s;
   logic                last_s;

   // Transfer qualification; ready is decoded from the state register.
   always_comb begin
      xfer_s    = in_valid && (state_r == S_LOAD);
      illegal_s = is_illegal(in_opcode);
      halt_s    = (in_opcode == OP_HALT);
      last_s    = (wr_ptr_r == LAST_ADDR);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; start is ignored while loading.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt_s = S_LOAD;
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_LOAD: begin
            if (!xfer_s) begin
               state_nxt_s = S_LOAD;
            end else if (illegal_s) begin
               state_nxt_s = S_ERR;
            end else if (halt_s) begin
               state_nxt_s = S_DONE;
            end else if (last_s) begin
               state_nxt_s = S_ERR;
            end else begin
               state_nxt_s = S_LOAD;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Output decode from the state register.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      core_rst = 1'b1;
      case (state_r)
         S_IDLE: begin
            core_rst = 1'b1;
         end
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_DONE: begin
            done     = 1'b1;
            core_rst = 1'b0;
         end
         S_ERR: begin
            err      = 1'b1;
         end
         default: begin
            core_rst = 1'b1;
         end
      endcase
   end

   // Write port, pointer, counter and error code. The pointer saturates at
   // the last address because the load always ends there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r     <= {ADDR_W{1'b0}};
         word_count_r <= {(ADDR_W+1){1'b0}};
         err_code_r   <= 2'b00;
         imem_we_r    <= 1'b0;
         imem_addr_r  <= {ADDR_W{1'b0}};
         imem_wdata_r <= 27'd0;
      end else begin
         imem_we_r <= 1'b0;
         case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  wr_ptr_r     <= {ADDR_W{1'b0}};
                  word_count_r <= {(ADDR_W+1){1'b0}};
                  err_code_r   <= 2'b00;
               end
            end
            S_LOAD: begin
               if (xfer_s) begin
                  if (illegal_s) begin
                     err_code_r <= 2'b01;
                  end else begin
                     imem_we_r    <= 1'b1;
                     imem_addr_r  <= wr_ptr_r;
                     imem_wdata_r <= {in_opcode, in_operand};
                     word_count_r <= word_count_r + {{ADDR_W{1'b0}}, 1'b1};
                     if (!last_s) begin
                        wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                     end
                     if (last_s && !halt_s) begin
                        err_code_r <= 2'b10;
                     end
                  end
               end
            end
            default: begin
               imem_we_r <= 1'b0;
            end
         endcase
      end
   end

   assign imem_we    = imem_we_r;
   assign imem_addr  = imem_addr_r;
   assign imem_wdata = imem_wdata_r;
   assign err_code   = err_code_r;
   assign word_count = word_count_r;

endmodule
